// File: rtl/user_input_entry_pkg.sv
// user_input_entry_pkg: shared io definitions for the user-input entry and display stages.
package user_input_entry_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [31:0] append_digit(input logic [31:0] v, input logic [3:0] d);
    return v * 32'd10 + {28'd0, d};
  endfunction
endpackage

// File: rtl/user_input_entry_key_debounce.sv
// key_debounce: 2-FF synchronizer, stable-count debouncer and one-cycle press pulse for an active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 2);

  logic         r_s1, r_s2, r_level, r_prev, r_armed;
  logic [W-1:0] r_cnt, r_arm_cnt;

  // Presses are only reported once a full released window has been seen, so a
  // key held through reset stays silent until it is released and pressed again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b1;
      r_prev    <= 1'b1;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_s1   <= i_key_n;
      r_s2   <= r_s1;
      r_prev <= r_level;
      if (r_s2 == r_level) r_cnt <= '0;
      else if (r_cnt == W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + 1'b1;
      if (!r_armed) begin
        r_arm_cnt <= r_s2 ? r_arm_cnt + 1'b1 : '0;
        r_armed   <= r_s2 && (r_arm_cnt == W'(DEBOUNCE_CYCLES + 1));
      end
    end
  end

  assign o_press = r_armed & r_prev & ~r_level;
endmodule

// File: rtl/user_input_entry.sv
// user_input_entry: debounced key-driven decimal entry that hands a committed value to the CPU.
module user_input_entry
  import user_input_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_req,
  input  logic [3:0]  SW,
  input  logic        key_digit_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  output logic [31:0] value,
  output logic        busy,
  output logic [3:0]  digit_count,
  output logic [31:0] input_data,
  output logic        input_valid,
  output logic        digit_err
);
  logic        w_digit, w_enter, w_clear;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_value, w_value_nxt, r_data, w_data_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic        r_valid, w_valid_nxt, r_err, w_err_nxt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit (.clk(clk), .reset(reset), .i_key_n(key_digit_n), .o_press(w_digit));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (.clk(clk), .reset(reset), .i_key_n(key_enter_n), .o_press(w_enter));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (.clk(clk), .reset(reset), .i_key_n(key_clear_n), .o_press(w_clear));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_value <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Dropping input_req wins over any key event; among keys clear > enter > digit.
  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_value_nxt = '0;
        w_count_nxt = '0;
        w_state_nxt = input_req ? S_ENTRY : S_IDLE;
      end
      S_ENTRY: begin
        if (!input_req) begin
          w_state_nxt = S_IDLE;
          w_value_nxt = '0;
          w_count_nxt = '0;
        end else if (w_clear) begin
          w_value_nxt = '0;
          w_count_nxt = '0;
        end else if (w_enter) begin
          w_data_nxt  = r_value;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_digit) begin
          if (SW > DIGIT_MAX || r_count >= 4'(MAX_DIGITS)) w_err_nxt = 1'b1;
          else begin
            w_value_nxt = append_digit(r_value, SW);
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
      S_DONE: begin
        if (!input_req) begin
          w_state_nxt = S_IDLE;
          w_value_nxt = '0;
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign value       = r_value;
  assign busy        = (r_state == S_ENTRY);
  assign digit_count = r_count;
  assign input_data  = r_data;
  assign input_valid = r_valid;
  assign digit_err   = r_err;
endmodule

// File: doc/user_input_entry.md
USER_INPUT_ENTRY -- requirements
Module: user_input_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 500000, consecutive stable sampled cycles before a key level is accepted (10 ms at 50 MHz).
REQ-002 Parameter: MAX_DIGITS, 8, maximum decimal digits accepted per entry (display width).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 input_req  input  1  level from CPU: an input instruction is waiting for data.
REQ-006 SW  input  4  digit value to append, binary 0-9.
REQ-007 key_digit_n  input  1  push button, active-low, asynchronous: append SW as a digit.
REQ-008 key_enter_n  input  1  push button, active-low, asynchronous: commit entry.
REQ-009 key_clear_n  input  1  push button, active-low, asynchronous: clear entry.
REQ-010 value  output  32  running entered value; drives the display stage's user-input operand.
REQ-011 busy  output  1  high while in ENTRY; drives the display stage's input_flag.
REQ-012 digit_count  output  4  digits accepted so far in current entry.
REQ-013 input_data  output  32  committed value; held until next commit or reset.
REQ-014 input_valid  output  1  one-cycle pulse: input_data is valid.
REQ-015 digit_err  output  1  one-cycle pulse: digit press rejected.

Function
REQ-016 Each key passes a 2-FF synchronizer and then a debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-017 A press event is a single-cycle pulse on the debounced high-to-low transition; release generates no event; a held key generates exactly one event.
REQ-018 FSM states: IDLE, ENTRY, DONE.
REQ-019 IDLE: value=0, digit_count=0, busy=0; input_req=1 -> ENTRY next cycle; key events ignored.
REQ-020 ENTRY: busy=1; events act on the edge after the event pulse.
REQ-021 ENTRY event priority when simultaneous: clear > enter > digit; lower-priority events in the same cycle are discarded.
REQ-022 Clear: value=0, digit_count=0, remain in ENTRY.
REQ-023 Digit with SW<=9 and digit_count<MAX_DIGITS: value=value*10+SW (32-bit, no overflow possible at MAX_DIGITS<=9), digit_count+1.
REQ-024 Digit with SW>9 or digit_count==MAX_DIGITS: value, digit_count unchanged; digit_err pulses one cycle.
REQ-025 Enter: input_data=value, input_valid=1 for exactly one cycle, -> DONE; enter with zero digits commits 0.
REQ-026 DONE: busy=0, value held; input_req=0 -> IDLE; key events ignored.
REQ-027 input_req falling while in ENTRY aborts -> IDLE; no input_valid; input_data unchanged.
REQ-028 Worst-case latency key stable low -> state update: DEBOUNCE_CYCLES+4 cycles.

Reset
REQ-029 Reset forces IDLE; value, input_data, digit_count = 0; busy, input_valid, digit_err = 0.
REQ-030 Reset sets synchronizer and debounced levels to released (1) and clears debounce counters; a key held through reset release produces no event until released and pressed again.
REQ-031 Reset mid-ENTRY discards partial entry; no input_valid.

Structure
REQ-032 FSM state encoding and the decimal-digit limit constant (9) reside in the shared io package used by the display stage.
REQ-033 One sub-module, key_debounce (synchronizer + counter + falling-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 input_req=1; digits SW=1,2,3; enter -> value steps 1,12,123; input_valid one cycle with input_data=123; busy 1->0.
REQ-035 In ENTRY press digit with SW=12 -> digit_err one pulse; value, digit_count unchanged.
REQ-036 Enter nine digits of 9 -> first eight accepted, value=99999999, ninth gives digit_err.
REQ-037 Key bouncing (toggle every 2 cycles for 20 cycles then held low) -> exactly one event; digit appended once.
REQ-038 Enter and clear events in same cycle with value=45 -> value=0, no input_valid, stay ENTRY.
REQ-039 input_req dropped after digits 7,8 -> IDLE, value=0, no input_valid, input_data keeps prior value; reset mid-entry -> all outputs 0.
